bit_flipper_chain: RTL and testbench



---
 rtl/bit_flipper_chain.sv | 125 ++++++++++++
 tb/tb_bit_flipper_chain.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bit_flipper_chain.sv
// bit_flipper_chain: pseudorandom word source, periodic single-bit error
// injector and mismatch detector, with all three datapath views exposed.
// Vectors are indexed [1:N]; bit 1 is the MSB.

// lfsr: Fibonacci LFSR, feedback enters bit 1 and the word shifts toward bit N.
module lfsr #(
    parameter int         N    = 5,
    parameter logic [1:N] TAPS = 5'b00101,
    parameter logic [1:N] I    = 5'b00010
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:N] q
);
    logic [1:N] state_q;
    logic [1:N] state_d;
    logic       fb;

    // Next word: XOR of tapped bits shifted in at the MSB end.
    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = {fb, state_q[1:N-1]};
    end

    // State register; the seed is nonzero so the all-zero lockup state is never entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= I;
        else        state_q <= state_d;
    end

    assign q = state_q;
endmodule

// flipper: inverts one bit of the stream every PERIOD cycles, walking the
// flipped position from bit 1 toward bit N and wrapping.
module flipper #(
    parameter int N      = 5,
    parameter int PERIOD = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:N] stream,
    output logic [1:N] out
);
    localparam int                 CNT_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]   LAST      = CNT_W'(PERIOD - 1);
    localparam logic [1:N]         MASK_INIT = {1'b1, {(N-1){1'b0}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:N]       mask_q;
    logic [1:N]       mask_d;
    logic             inject;

    // Injection happens in the last slot of each period; the mask advances
    // on that same edge so the next injection hits the following bit.
    always_comb begin
        inject = (cnt_q == LAST);
        cnt_d  = inject ? '0 : cnt_q + 1'b1;
        mask_d = inject ? {mask_q[N], mask_q[1:N-1]} : mask_q;
        out    = stream ^ (inject ? mask_q : '0);
    end

    // Schedule state; reset restarts the period and the bit position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            mask_q <= MASK_INIT;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end
endmodule

// err_checker: combinational per-bit compare of corrupted and clean streams.
module err_checker #(
    parameter int N = 5
) (
    input  logic [1:N] errStream,
    input  logic [1:N] inpStream,
    output logic [1:N] bitError,
    output logic       error
);
    // Any differing bit is flagged in place and summarised on error.
    always_comb begin
        bitError = errStream ^ inpStream;
        error    = |bitError;
    end
endmodule

// Top-level wrapper chaining source, injector and detector.
module bit_flipper_chain #(
    parameter int         N      = 5,
    parameter logic [1:N] TAPS   = 5'b00101,
    parameter logic [1:N] I      = 5'b00010,
    parameter int         PERIOD = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:N] stream,
    output logic [1:N] q,
    output logic [1:N] bitError,
    output logic       error
);
    lfsr #(.N(N), .TAPS(TAPS), .I(I)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (stream)
    );

    flipper #(.N(N), .PERIOD(PERIOD)) u_flipper (
        .clk    (clk),
        .reset  (reset),
        .stream (stream),
        .out    (q)
    );

    err_checker #(.N(N)) u_checker (
        .errStream (q),
        .inpStream (stream),
        .bitError  (bitError),
        .error     (error)
    );
endmodule

// File: tb/tb_bit_flipper_chain.sv
// Scoreboard bench: the stimulus process pushes the expected outputs for each
// cycle; a monitor pops one entry per falling edge and compares.
// u_a uses PERIOD=3, u_b uses PERIOD=1 (inject every cycle).
module tb_bit_flipper_chain;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:N] stream_a, q_a, be_a;
    logic       err_a;
    logic [1:N] stream_b, q_b, be_b;
    logic       err_b;
    logic [1:N] c_err, c_inp, c_be;
    logic       c_e;

    bit_flipper_chain #(.N(N), .TAPS(5'b00101), .I(5'b00010), .PERIOD(3)) u_a (
        .clk(clk), .reset(reset), .stream(stream_a), .q(q_a), .bitError(be_a), .error(err_a)
    );

    bit_flipper_chain #(.N(N), .TAPS(5'b00101), .I(5'b00010), .PERIOD(1)) u_b (
        .clk(clk), .reset(reset), .stream(stream_b), .q(q_b), .bitError(be_b), .error(err_b)
    );

    err_checker #(.N(N)) u_chk (
        .errStream(c_err), .inpStream(c_inp), .bitError(c_be), .error(c_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [1:N] s;
        logic [1:N] qa;
        logic [1:N] bea;
        logic [1:N] qb;
        logic [1:N] beb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Hand-computed first 15 post-reset cycles for PERIOD=3.
    logic [1:N] tab_s [15] = '{5'b00010, 5'b00001, 5'b10000, 5'b01000, 5'b00100,
                               5'b10010, 5'b01001, 5'b10100, 5'b11010, 5'b01101,
                               5'b00110, 5'b10011, 5'b11001, 5'b11100, 5'b11110};
    logic [1:N] tab_q [15] = '{5'b00010, 5'b00001, 5'b00000, 5'b01000, 5'b00100,
                               5'b11010, 5'b01001, 5'b10100, 5'b11110, 5'b01101,
                               5'b00110, 5'b10001, 5'b11001, 5'b11100, 5'b11111};
    logic [1:N] tab_be[15] = '{5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000,
                               5'b01000, 5'b00000, 5'b00000, 5'b00100, 5'b00000,
                               5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00001};

    logic [1:N] ms;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %b expected %b", name, k, act[4:0], exp[4:0]);
        end
    endtask

    function automatic logic [1:N] onehot(input int k);
        logic [1:N] m;
        m = '0;
        m[1 + (k % N)] = 1'b1;
        return m;
    endfunction

    task automatic push_reset();
        exp_t e;
        e.k = -1; e.s = 5'b00010; e.qa = 5'b00010; e.bea = 5'b00000;
        e.qb = 5'b10010; e.beb = 5'b10000;
        sb.push_back(e);
    endtask

    task automatic push_cycle(input int k);
        exp_t e;
        e.k = k;
        if (k < 15) begin
            e.s   = tab_s[k];
            e.qa  = tab_q[k];
            e.bea = tab_be[k];
            if (k == 14) ms = tab_s[14];
        end else begin
            ms    = {ms[3] ^ ms[5], ms[1:4]};
            e.s   = ms;
            e.bea = (k % 3 == 2) ? onehot(k / 3) : 5'b00000;
            e.qa  = ms ^ e.bea;
        end
        e.beb = onehot(k);
        e.qb  = e.s ^ e.beb;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stream_a", e.k, 32'(stream_a), 32'(e.s));
                chk("q_a",      e.k, 32'(q_a),      32'(e.qa));
                chk("bitErr_a", e.k, 32'(be_a),     32'(e.bea));
                chk("error_a",  e.k, 32'(err_a),    32'(|e.bea));
                chk("onehot_a", e.k, 32'($countones(be_a) <= 1), 32'd1);
                chk("stream_b", e.k, 32'(stream_b), 32'(e.s));
                chk("q_b",      e.k, 32'(q_b),      32'(e.qb));
                chk("bitErr_b", e.k, 32'(be_b),     32'(e.beb));
                chk("error_b",  e.k, 32'(err_b),    32'(|e.beb));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int w;
        reset = 1'b0;
        c_err = '0;
        c_inp = '0;
        ms    = '0;

        repeat (2) begin
            @(posedge clk); #1;
            push_reset();
        end
        @(posedge clk); #1;
        reset = 1'b1;
        push_cycle(0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            push_cycle(k);
        end

        // Mid-cycle reset must take effect without a clock edge.
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("async_stream_a", -2, 32'(stream_a), 32'(5'b00010));
        chk("async_q_a",      -2, 32'(q_a),      32'(5'b00010));
        chk("async_error_a",  -2, 32'(err_a),    32'd0);
        chk("async_q_b",      -2, 32'(q_b),      32'(5'b10010));
        chk("async_error_b",  -2, 32'(err_b),    32'd1);
        @(posedge clk); #1;
        push_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        push_cycle(0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            push_cycle(k);
        end

        // Standalone checker.
        c_err = 5'b10110; c_inp = 5'b10011; #1;
        chk("chk_bitError", -3, 32'(c_be), 32'(5'b00101));
        chk("chk_error",    -3, 32'(c_e),  32'd1);
        c_err = 5'b01101; c_inp = 5'b01101; #1;
        chk("chk_eq_bitError", -3, 32'(c_be), 32'd0);
        chk("chk_eq_error",    -3, 32'(c_e),  32'd0);
        c_err = 5'b00000; c_inp = 5'b11111; #1;
        chk("chk_all_bitError", -3, 32'(c_be), 32'(5'b11111));

        w = 0;
        while (sb.size() > 0 && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        if (sb.size() > 0) chk("drain", -4, 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
